slot_bank_ctrl: RTL and testbench
=================================

SLOT_BANK_CTRL -- requirements
Module: slot_bank_ctrl

Interface
REQ-001 Parameter NUM_REELS, default 4, number of reel symbols compared per spin (2..8).
REQ-002 Parameter REEL_W, default 4, width of one reel symbol.
REQ-003 Parameter BAL_W, default 27, width of balance and arithmetic.
REQ-004 Parameter BAL_INIT, default 100, balance after reset.
REQ-005 Parameter BAL_MAX, default 1000, balance saturation ceiling.
REQ-006 Parameter WIN_MULT, default 2, payout multiplier on full reel match.
REQ-007 clk  input  1  clock; reset rst, synchronous, active-high; all state updates on posedge clk.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 bet_sel  input  4  bet switches [3]=100,[2]=50,[1]=10,[0]=1; priority 100>50>10>1.
REQ-010 spin_req  input  1  request to place bet and start spin.
REQ-011 reels_valid  input  1  reels bus holds a spin result this cycle.
REQ-012 reels  input  NUM_REELS*REEL_W  packed reel symbols, reel 0 in LSBs.
REQ-013 balance  output  BAL_W  current registered balance.
REQ-014 busy  output  1  high while a spin is outstanding.
REQ-015 spin_done  output  1  one-cycle pulse, spin settled.
REQ-016 win  output  1  one-cycle pulse coincident with spin_done when reels all matched.
REQ-017 reject  output  1  one-cycle pulse, spin_req refused for insufficient balance.

Function
REQ-018 FSM states IDLE, WAIT_RESULT, PAYOUT; encoding per shared package.
REQ-019 IDLE: spin_req=1 with decoded bet B>0 and balance>=B SHALL latch B, write balance-B, go WAIT_RESULT; new balance visible next cycle.
REQ-020 IDLE: spin_req=1 with B>0 and balance<B SHALL pulse reject next cycle, balance unchanged, stay IDLE.
REQ-021 IDLE: spin_req=1 with bet_sel=0 SHALL be ignored (no reject, no state change).
REQ-022 WAIT_RESULT: reels_valid=1 SHALL capture reels and go PAYOUT; spin_req ignored.
REQ-023 PAYOUT: all NUM_REELS symbols equal SHALL credit min(balance+B*WIN_MULT, BAL_MAX) and pulse win; otherwise balance unchanged.
REQ-024 PAYOUT SHALL pulse spin_done and return to IDLE after exactly one cycle; result visible 2 cycles after reels_valid.
REQ-025 busy SHALL be high in WAIT_RESULT and PAYOUT, low in IDLE.
REQ-026 reels_valid in IDLE or PAYOUT SHALL be ignored.
REQ-027 Credit arithmetic SHALL be computed at BAL_W+4 bits before saturation; no wrap-around.
REQ-028 Balance SHALL never go below 0 nor exceed BAL_MAX.

Reset
REQ-029 rst SHALL force IDLE, balance=BAL_INIT, busy/spin_done/win/reject=0, latched bet=0.
REQ-030 rst during WAIT_RESULT or PAYOUT SHALL forfeit the pending bet with no payout.
REQ-031 rst SHALL take priority over every simultaneous input.

Configuration
REQ-032 Macro SLOT_JACKPOT_EN defined: jackpot pool register (BAL_W) seeded to BAL_INIT on reset, +1 per accepted bet (saturating BAL_MAX); full match of symbol all-ones additionally credits pool (total still saturated at BAL_MAX) and reseeds pool to BAL_INIT; extra output jackpot pulses with win.
REQ-033 Macro undefined: no pool register, jackpot output present and tied 0, all-ones match pays as any match.

Structure
REQ-034 Package slot_pkg SHALL hold FSM state typedef, bet constants 1/10/50/100, and the bet_sel decode function.
REQ-035 Sub-module slot_reel_match (combinational, NUM_REELS/REEL_W parameters) SHALL produce all_equal and all_ones flags.

Verification
REQ-036 Reset, bet_sel=4'b0100, spin_req, reels=4x4'h3 -> balance 50 then 150, win=1, spin_done=1.
REQ-037 Balance 100, bet 100, reels 3,3,3,5 -> balance 0; next spin bet 1 -> reject pulse, balance 0.
REQ-038 Balance 990, bet 10 match -> 980 then saturates 1000.
REQ-039 spin_req with bet_sel=0 -> no state change; rst in WAIT_RESULT -> balance 100, busy 0, no spin_done.
REQ-040 SLOT_JACKPOT_EN, 5 bets of 1 non-matching, then bet 1 reels all 4'hF -> pool 106 credited, jackpot=1, pool reseeded 100.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types and helpers for the slot bank controller: FSM state encoding,
// bet denominations and the bet switch decoder.
package slot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_RESULT = 2'd1,
        ST_PAYOUT      = 2'd2
    } slot_state_e;

    localparam logic [7:0] BET_1   = 8'd1;
    localparam logic [7:0] BET_10  = 8'd10;
    localparam logic [7:0] BET_50  = 8'd50;
    localparam logic [7:0] BET_100 = 8'd100;

    // Highest switch wins; zero means no bet selected.
    function automatic logic [7:0] decode_bet(input logic [3:0] sel);
        logic [7:0] bet;
        bet = 8'd0;
        if (sel[3])      bet = BET_100;
        else if (sel[2]) bet = BET_50;
        else if (sel[1]) bet = BET_10;
        else if (sel[0]) bet = BET_1;
        return bet;
    endfunction

endpackage

// File: rtl/slot_reel_match.sv
// Combinational reel comparator: flags when every reel shows the same symbol,
// and when that common symbol is all ones.
module slot_reel_match #(
    parameter int NUM_REELS = 4,
    parameter int REEL_W    = 4
) (
    input  logic [NUM_REELS*REEL_W-1:0] reels,
    output logic                        all_equal,
    output logic                        all_ones
);

    always_comb begin
        all_equal = 1'b1;
        for (int i = 1; i < NUM_REELS; i++) begin
            if (reels[i*REEL_W +: REEL_W] != reels[REEL_W-1:0]) all_equal = 1'b0;
        end
        all_ones = all_equal && (reels[REEL_W-1:0] == {REEL_W{1'b1}});
    end

endmodule

// File: rtl/slot_bank_ctrl.sv
// Slot machine bank controller: takes bets, waits for a reel result and pays
// out with saturation. Define SLOT_JACKPOT_EN to add the progressive jackpot pool.
module slot_bank_ctrl
    import slot_pkg::*;
#(
    parameter int NUM_REELS = 4,
    parameter int REEL_W    = 4,
    parameter int BAL_W     = 27,
    parameter int BAL_INIT  = 100,
    parameter int BAL_MAX   = 1000,
    parameter int WIN_MULT  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  bet_sel,
    input  logic                        spin_req,
    input  logic                        reels_valid,
    input  logic [NUM_REELS*REEL_W-1:0] reels,
    output logic [BAL_W-1:0]            balance,
    output logic                        busy,
    output logic                        spin_done,
    output logic                        win,
    output logic                        reject,
    output logic                        jackpot
);

    localparam int WW = BAL_W + 4;
    localparam logic [WW-1:0]    MAX_W    = WW'(BAL_MAX);
    localparam logic [BAL_W-1:0] INIT_BAL = BAL_W'(BAL_INIT);

    // Wide sums are clamped here so the balance can never wrap past the ceiling.
    function automatic logic [BAL_W-1:0] sat_bal(input logic [WW-1:0] v);
        if (v > MAX_W) return BAL_W'(BAL_MAX);
        return v[BAL_W-1:0];
    endfunction

    slot_state_e                 state_q, state_d;
    logic [BAL_W-1:0]            bal_q, bal_d;
    logic [BAL_W-1:0]            bet_q, bet_d;
    logic [NUM_REELS*REEL_W-1:0] reels_q, reels_d;
    logic                        spin_done_q, spin_done_d;
    logic                        win_q, win_d;
    logic                        reject_q, reject_d;
    logic [BAL_W-1:0]            bet_dec;
    logic [WW-1:0]               credit_w;
    logic                        all_equal, all_ones;

    assign bet_dec  = BAL_W'(decode_bet(bet_sel));
    assign credit_w = {4'b0, bal_q} + {4'b0, bet_q} * WW'(WIN_MULT);

    slot_reel_match #(
        .NUM_REELS(NUM_REELS),
        .REEL_W   (REEL_W)
    ) u_match (
        .reels    (reels_q),
        .all_equal(all_equal),
        .all_ones (all_ones)
    );

`ifdef SLOT_JACKPOT_EN
    logic [BAL_W-1:0] pool_q, pool_d;
    logic             jackpot_q, jackpot_d;
    assign jackpot = jackpot_q;
`else
    logic unused_all_ones;
    assign unused_all_ones = all_ones;
    assign jackpot         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bal_d       = bal_q;
        bet_d       = bet_q;
        reels_d     = reels_q;
        spin_done_d = 1'b0;
        win_d       = 1'b0;
        reject_d    = 1'b0;
`ifdef SLOT_JACKPOT_EN
        pool_d      = pool_q;
        jackpot_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (spin_req && (bet_dec != '0)) begin
                    if (bal_q >= bet_dec) begin
                        bet_d   = bet_dec;
                        bal_d   = bal_q - bet_dec;
                        state_d = ST_WAIT_RESULT;
`ifdef SLOT_JACKPOT_EN
                        pool_d  = sat_bal({4'b0, pool_q} + WW'(1));
`endif
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_WAIT_RESULT: begin
                if (reels_valid) begin
                    reels_d = reels;
                    state_d = ST_PAYOUT;
                end
            end
            ST_PAYOUT: begin
                spin_done_d = 1'b1;
                state_d     = ST_IDLE;
                if (all_equal) begin
                    win_d = 1'b1;
                    bal_d = sat_bal(credit_w);
`ifdef SLOT_JACKPOT_EN
                    if (all_ones) begin
                        bal_d     = sat_bal(credit_w + {4'b0, pool_q});
                        pool_d    = INIT_BAL;
                        jackpot_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bal_q       <= INIT_BAL;
            bet_q       <= '0;
            spin_done_q <= 1'b0;
            win_q       <= 1'b0;
            reject_q    <= 1'b0;
`ifdef SLOT_JACKPOT_EN
            pool_q      <= INIT_BAL;
            jackpot_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bal_q       <= bal_d;
            bet_q       <= bet_d;
            spin_done_q <= spin_done_d;
            win_q       <= win_d;
            reject_q    <= reject_d;
`ifdef SLOT_JACKPOT_EN
            pool_q      <= pool_d;
            jackpot_q   <= jackpot_d;
`endif
        end
    end

    // Captured reels are only read in PAYOUT, which is always preceded by a capture.
    always_ff @(posedge clk) begin
        reels_q <= reels_d;
    end

    assign balance   = bal_q;
    assign busy      = (state_q != ST_IDLE);
    assign spin_done = spin_done_q;
    assign win       = win_q;
    assign reject    = reject_q;

endmodule

// File: tb/tb_slot_bank_ctrl.sv
// Directed testbench for slot_bank_ctrl with default parameters.
module tb_slot_bank_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  bet_sel;
    logic        spin_req;
    logic        reels_valid;
    logic [15:0] reels;
    logic [26:0] balance;
    logic        busy, spin_done, win, reject, jackpot;

    int errors = 0;
    int checks = 0;

    slot_bank_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bet_sel    (bet_sel),
        .spin_req   (spin_req),
        .reels_valid(reels_valid),
        .reels      (reels),
        .balance    (balance),
        .busy       (busy),
        .spin_done  (spin_done),
        .win        (win),
        .reject     (reject),
        .jackpot    (jackpot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full bet/result/payout sequence; returns with payout pulses visible.
    task automatic do_spin(input logic [3:0] bs, input logic [15:0] rv);
        bet_sel  = bs;
        spin_req = 1'b1;
        tick();
        spin_req    = 1'b0;
        reels_valid = 1'b1;
        reels       = rv;
        tick();
        reels_valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bet_sel = 4'b0; spin_req = 1'b0; reels_valid = 1'b0; reels = 16'h0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_balance", 32'(balance), 32'd100);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_spin_done", 32'(spin_done), 32'd0);
        check("reset_win", 32'(win), 32'd0);
        check("reset_reject", 32'(reject), 32'd0);
        check("reset_jackpot", 32'(jackpot), 32'd0);

        // Bet 50 and a full match
        bet_sel = 4'b0100; spin_req = 1'b1;
        tick();
        spin_req = 1'b0;
        check("bet50_debit", 32'(balance), 32'd50);
        check("bet50_busy", 32'(busy), 32'd1);
        reels_valid = 1'b1; reels = 16'h3333;
        tick();
        reels_valid = 1'b0;
        check("payout_busy", 32'(busy), 32'd1);
        check("payout_no_done_yet", 32'(spin_done), 32'd0);
        check("payout_bal_pending", 32'(balance), 32'd50);
        tick();
        check("win_balance", 32'(balance), 32'd150);
        check("win_done", 32'(spin_done), 32'd1);
        check("win_pulse", 32'(win), 32'd1);
        check("win_idle", 32'(busy), 32'd0);
        tick();
        check("done_one_cycle", 32'(spin_done), 32'd0);
        check("win_one_cycle", 32'(win), 32'd0);

        // Lose everything, then an unaffordable bet is rejected
        do_reset();
        do_spin(4'b1000, 16'h5333);
        check("lose_balance", 32'(balance), 32'd0);
        check("lose_done", 32'(spin_done), 32'd1);
        check("lose_no_win", 32'(win), 32'd0);
        bet_sel = 4'b0001; spin_req = 1'b1;
        tick();
        spin_req = 1'b0;
        check("reject_pulse", 32'(reject), 32'd1);
        check("reject_balance", 32'(balance), 32'd0);
        check("reject_idle", 32'(busy), 32'd0);
        tick();
        check("reject_one_cycle", 32'(reject), 32'd0);

        // Climb to the ceiling with bet-100 wins
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            do_spin(4'b1000, 16'h1111);
            check("climb_balance", 32'(balance), 32'(100 + 100 * k));
        end
        do_spin(4'b0100, 16'h2222);
        check("sat_over_max", 32'(balance), 32'd1000);
        check("sat_win", 32'(win), 32'd1);
        do_spin(4'b0010, 16'h1234);
        check("to_990", 32'(balance), 32'd990);
        check("to_990_no_win", 32'(win), 32'd0);
        bet_sel = 4'b0010; spin_req = 1'b1;
        tick();
        spin_req = 1'b0;
        check("bet10_debit", 32'(balance), 32'd980);
        reels_valid = 1'b1; reels = 16'h9999;
        tick();
        reels_valid = 1'b0;
        tick();
        check("bet10_saturate", 32'(balance), 32'd1000);
        check("bet10_win", 32'(win), 32'd1);

        // Priority decode, spin_req ignored while waiting, reels_valid ignored outside WAIT
        bet_sel = 4'b1111; spin_req = 1'b1;
        tick();
        check("priority_100", 32'(balance), 32'd900);
        reels_valid = 1'b1; reels = 16'h7770;
        tick();
        spin_req = 1'b0;
        tick();
        check("mismatch_balance", 32'(balance), 32'd900);
        check("mismatch_done", 32'(spin_done), 32'd1);
        check("mismatch_no_win", 32'(win), 32'd0);
        reels = 16'h8888;
        tick();
        reels_valid = 1'b0;
        check("idle_reels_ignored_busy", 32'(busy), 32'd0);
        check("idle_reels_ignored_done", 32'(spin_done), 32'd0);

        // Zero bet is ignored
        bet_sel = 4'b0000; spin_req = 1'b1;
        tick();
        spin_req = 1'b0;
        check("zero_bet_balance", 32'(balance), 32'd900);
        check("zero_bet_busy", 32'(busy), 32'd0);
        check("zero_bet_reject", 32'(reject), 32'd0);

        // Reset while waiting forfeits the bet
        do_reset();
        bet_sel = 4'b0010; spin_req = 1'b1;
        tick();
        spin_req = 1'b0;
        check("pre_rst_debit", 32'(balance), 32'd90);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_wait_balance", 32'(balance), 32'd100);
        check("rst_wait_busy", 32'(busy), 32'd0);
        check("rst_wait_done", 32'(spin_done), 32'd0);
        reels_valid = 1'b1; reels = 16'h4444;
        tick();
        reels_valid = 1'b0;
        tick();
        check("rst_no_payout_done", 32'(spin_done), 32'd0);
        check("rst_no_payout_bal", 32'(balance), 32'd100);

        // Reset beats a simultaneous spin request
        rst = 1'b1; bet_sel = 4'b1000; spin_req = 1'b1;
        tick();
        rst = 1'b0; spin_req = 1'b0;
        check("rst_priority_bal", 32'(balance), 32'd100);
        check("rst_priority_busy", 32'(busy), 32'd0);

`ifdef SLOT_JACKPOT_EN
        for (int k = 0; k < 5; k++) do_spin(4'b0001, 16'h0001);
        check("jp_after_losses", 32'(balance), 32'd95);
        do_spin(4'b0001, 16'hFFFF);
        check("jp_balance", 32'(balance), 32'd202);
        check("jp_pulse", 32'(jackpot), 32'd1);
        check("jp_win", 32'(win), 32'd1);
        do_spin(4'b0001, 16'hFFFF);
        check("jp_reseeded", 32'(balance), 32'd304);
        check("jp_pulse2", 32'(jackpot), 32'd1);
`else
        do_spin(4'b0001, 16'hFFFF);
        check("ones_plain_balance", 32'(balance), 32'd101);
        check("ones_plain_win", 32'(win), 32'd1);
        check("ones_no_jackpot", 32'(jackpot), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
